// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each FU result lands in a small FIFO, and the FIFO heads are
// drained round-robin onto WAYS registered broadcast lanes.

module cdb_fu_fifo #(
  parameter int EW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] dout,
  output logic          ready,
  output logic          nonempty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;

  // ready looks only at the registered count, so a full FIFO refuses even while popping
  assign ready    = (count_q < FULL);
  assign nonempty = (count_q != '0);
  assign dout     = mem_q[rd_ptr_q];
  assign do_push  = push && ready;
  assign do_pop   = pop && nonempty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (squash) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

module cdb_arbiter #(
  parameter int WAYS   = 3,
  parameter int NUM_FU = 5,
  parameter int XLEN   = 64,
  parameter int PRF    = 64,
  parameter int ROB    = 16,
  parameter int DEPTH  = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
  input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]   fu_prf_idx,
  input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]   fu_rob_idx,
  output logic [NUM_FU-1:0]                    fu_ready,
  output logic [WAYS-1:0]                      CDB_valid,
  output logic [WAYS-1:0][XLEN-1:0]            CDB_Data,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]     CDB_PRF_idx,
  output logic [WAYS-1:0][$clog2(ROB)-1:0]     CDB_rob_idx
);
  localparam int PW = $clog2(PRF);
  localparam int RW = $clog2(ROB);
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int NW = $clog2(WAYS + 1);
  localparam logic [FW:0] NF = (FW+1)'(NUM_FU);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [PW-1:0]   prf;
    logic [RW-1:0]   rob;
  } res_t;

  res_t [NUM_FU-1:0] head;
  logic [NUM_FU-1:0] nonempty, pop;
  res_t [WAYS-1:0]   lane_q, lane_d;
  logic [WAYS-1:0]   valid_q, valid_d;
  logic [FW-1:0]     rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    cdb_fu_fifo #(.EW($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .push     (fu_valid[g]),
      .pop      (pop[g]),
      .din      ({fu_data[g], fu_prf_idx[g], fu_rob_idx[g]}),
      .dout     (head[g]),
      .ready    (fu_ready[g]),
      .nonempty (nonempty[g])
    );
  end

  // Scan from rr_ptr; the n-th non-empty FU found lands on lane n.
  always_comb begin
    logic [FW:0]   sum;
    logic [NW-1:0] n;
    sum      = '0;
    n        = '0;
    pop      = '0;
    lane_d   = '0;
    valid_d  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int s = 0; s < NUM_FU; s++) begin
      sum = {1'b0, rr_ptr_q} + (FW+1)'(s);
      if (sum >= NF) sum = sum - NF;
      for (int f = 0; f < NUM_FU; f++) begin
        if (sum == (FW+1)'(f) && nonempty[f] && n < NW'(WAYS)) begin
          pop[f] = 1'b1;
          for (int k = 0; k < WAYS; k++) begin
            if (n == NW'(k)) begin
              lane_d[k]  = head[f];
              valid_d[k] = 1'b1;
            end
          end
          n        = n + NW'(1);
          rr_ptr_d = (f == NUM_FU - 1) ? '0 : FW'(f + 1);
        end
      end
    end
    // a flush kills the whole cycle's grants but keeps the fairness pointer
    if (squash) begin
      pop      = '0;
      lane_d   = '0;
      valid_d  = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      lane_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign CDB_valid = valid_q;
  for (genvar k = 0; k < WAYS; k++) begin : g_lane
    assign CDB_Data[k]    = lane_q[k].data;
    assign CDB_PRF_idx[k] = lane_q[k].prf;
    assign CDB_rob_idx[k] = lane_q[k].rob;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-FU expected queues, directed arbitration cases and a random stream.

module tb_cdb_arbiter;
  localparam int WAYS = 3, NUM_FU = 5, XLEN = 64, PRF = 64, ROB = 16, DEPTH = 2;

  logic clock = 1'b0;
  logic reset, squash;
  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0][XLEN-1:0] fu_data;
  logic [NUM_FU-1:0][5:0]      fu_prf_idx;
  logic [NUM_FU-1:0][3:0]      fu_rob_idx;
  logic [NUM_FU-1:0]           fu_ready;
  logic [WAYS-1:0]             CDB_valid;
  logic [WAYS-1:0][XLEN-1:0]   CDB_Data;
  logic [WAYS-1:0][5:0]        CDB_PRF_idx;
  logic [WAYS-1:0][3:0]        CDB_rob_idx;

  cdb_arbiter #(.WAYS(WAYS), .NUM_FU(NUM_FU), .XLEN(XLEN), .PRF(PRF), .ROB(ROB), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_data(fu_data), .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready), .CDB_valid(CDB_valid), .CDB_Data(CDB_Data),
    .CDB_PRF_idx(CDB_PRF_idx), .CDB_rob_idx(CDB_rob_idx)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [63:0] d; logic [5:0] p; logic [3:0] r; } ent_t;

  ent_t              sbq [NUM_FU][$];
  ent_t              pend_e [NUM_FU];
  logic [NUM_FU-1:0] pend_v;
  logic              pend_sq;
  int                n_chk = 0, n_pass = 0, seq = 0;
  bit                fu1_blocked = 0;
  localparam logic [NUM_FU-1:0] ALL_RDY = {NUM_FU{1'b1}};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic drive(input int f, input logic [63:0] d, input logic [5:0] p, input logic [3:0] r);
    fu_valid[f]   = 1'b1;
    fu_data[f]    = d;
    fu_prf_idx[f] = p;
    fu_rob_idx[f] = r;
  endtask

  task automatic clear_sb();
    for (int f = 0; f < NUM_FU; f++) sbq[f].delete();
    pend_v = '0;
  endtask

  // Record accepted pushes, let one edge pass, then check the CDB against the queues.
  // Pushes of this edge are only queued after the check, so a bypass shows up as unexpected.
  task automatic cycle();
    ent_t e;
    bit found;
    logic [NUM_FU-1:0] used, exp_rdy;
    pend_sq = squash;
    for (int f = 0; f < NUM_FU; f++) begin
      pend_v[f] = reset && !squash && fu_valid[f] && fu_ready[f];
      pend_e[f] = {fu_data[f], fu_prf_idx[f], fu_rob_idx[f]};
    end
    @(negedge clock);
    check("lanes_packed", 64'(CDB_valid & (CDB_valid + 1'b1)), 64'd0);
    used = '0;
    for (int k = 0; k < WAYS; k++) begin
      e = {CDB_Data[k], CDB_PRF_idx[k], CDB_rob_idx[k]};
      if (CDB_valid[k]) begin
        found = 0;
        for (int f = 0; f < NUM_FU; f++) begin
          if (!found && sbq[f].size() > 0 && sbq[f][0] == e) begin
            found = 1;
            check("lane_one_per_fu", 64'(used[f]), 64'd0);
            used[f] = 1'b1;
            void'(sbq[f].pop_front());
          end
        end
        check("lane_expected", 64'(found), 64'd1);
      end else begin
        check("idle_lane_zero", 64'(e != '0), 64'd0);
      end
    end
    for (int f = 0; f < NUM_FU; f++) begin
      if (pend_sq) sbq[f].delete();
      else if (pend_v[f]) sbq[f].push_back(pend_e[f]);
      exp_rdy[f] = (sbq[f].size() < DEPTH);
    end
    pend_v = '0;
    check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    if (!fu_ready[1]) fu1_blocked = 1;
  endtask

  initial begin
    int total;
    reset = 1'b0; squash = 1'b0; pend_v = '0;
    fu_data = '0; fu_prf_idx = '0; fu_rob_idx = '0;
    fu_valid = '1;
    #1;
    check("rst_valid", 64'(CDB_valid), 64'd0);
    check("rst_ready", 64'(fu_ready), 64'(ALL_RDY));
    repeat (2) @(negedge clock);
    check("rst_hold_valid", 64'(CDB_valid), 64'd0);
    check("rst_hold_ready", 64'(fu_ready), 64'(ALL_RDY));
    fu_valid = '0;
    reset = 1'b1;
    cycle(); cycle();
    check("rst_no_leak", 64'(CDB_valid), 64'd0);

    // all five FUs at once, pointer at 0
    for (int f = 0; f < NUM_FU; f++) drive(f, 64'h1000 + 64'(f), 6'(10 + f), 4'(f));
    cycle();
    check("t34_latency", 64'(CDB_valid), 64'd0);
    fu_valid = '0;
    cycle();
    check("t34_v1", 64'(CDB_valid), 64'b111);
    for (int k = 0; k < 3; k++) begin
      check("t34_c1_data", CDB_Data[k], 64'h1000 + 64'(k));
      check("t34_c1_prf", 64'(CDB_PRF_idx[k]), 64'(10 + k));
    end
    cycle();
    check("t34_v2", 64'(CDB_valid), 64'b011);
    check("t34_c2_l0", CDB_Data[0], 64'h1003);
    check("t34_c2_l1", CDB_Data[1], 64'h1004);
    cycle();
    check("t34_idle", 64'(CDB_valid), 64'd0);

    // single push from FU2
    drive(2, 64'hDEAD, 6'd7, 4'd3);
    cycle();
    check("t33_latency", 64'(CDB_valid), 64'd0);
    fu_valid = '0;
    cycle();
    check("t33_valid", 64'(CDB_valid), 64'b001);
    check("t33_data", CDB_Data[0], 64'hDEAD);
    check("t33_prf", 64'(CDB_PRF_idx[0]), 64'd7);
    check("t33_rob", 64'(CDB_rob_idx[0]), 64'd3);
    cycle();
    check("t33_after", 64'(CDB_valid), 64'd0);

    // pointer now 3: FUs 0,1,3 must come out as 3,0,1
    drive(0, 64'h2000, 6'd20, 4'd0);
    drive(1, 64'h2001, 6'd21, 4'd1);
    drive(3, 64'h2003, 6'd23, 4'd3);
    cycle();
    fu_valid = '0;
    cycle();
    check("rr_valid", 64'(CDB_valid), 64'b111);
    check("rr_l0", CDB_Data[0], 64'h2003);
    check("rr_l1", CDB_Data[1], 64'h2001 - 64'd1);
    check("rr_l2", CDB_Data[2], 64'h2001);
    cycle();

    // pointer now 2: FU3 alone, then everyone, leaves pointer at 4 with FIFOs non-empty
    drive(3, 64'h2103, 6'd33, 4'd3);
    cycle();
    for (int f = 0; f < NUM_FU; f++) drive(f, 64'h2200 + 64'(f), 6'(40 + f), 4'(f));
    cycle();
    fu_valid = '0;
    check("t37_pre_valid", 64'(CDB_valid), 64'b001);
    #2 reset = 1'b0;
    #1;
    check("t37_valid", 64'(CDB_valid), 64'd0);
    check("t37_data0", CDB_Data[0], 64'd0);
    check("t37_prf0", 64'(CDB_PRF_idx[0]), 64'd0);
    check("t37_ready", 64'(fu_ready), 64'(ALL_RDY));
    clear_sb();
    @(negedge clock);
    reset = 1'b1;
    for (int f = 0; f < NUM_FU; f++) drive(f, 64'h3000 + 64'(f), 6'(50 + f), 4'(f));
    cycle();
    check("t37_post_latency", 64'(CDB_valid), 64'd0);
    fu_valid = '0;
    cycle();
    check("t37_rr_l0", CDB_Data[0], 64'h3000);
    check("t37_rr_l2", CDB_Data[2], 64'h3002);
    repeat (2) cycle();

    // every FU streams every cycle: FU1 must back-pressure without losing anything
    for (int c = 0; c < 40; c++) begin
      for (int f = 0; f < NUM_FU; f++) drive(f, {4'(f), 28'(seq), $urandom}, 6'($urandom), 4'($urandom));
      seq++;
      cycle();
    end
    fu_valid = '0;
    check("t35_fu1_backpressure", 64'(fu1_blocked), 64'd1);
    repeat (6) cycle();

    // fill, then squash alongside a FU0 push that must vanish
    for (int c = 0; c < 2; c++) begin
      for (int f = 0; f < NUM_FU; f++) drive(f, {4'(f), 28'(seq), $urandom}, 6'($urandom), 4'($urandom));
      seq++;
      cycle();
    end
    fu_valid = '0;
    squash = 1'b1;
    drive(0, 64'hBAD0, 6'd63, 4'd15);
    cycle();
    check("t36_valid", 64'(CDB_valid), 64'd0);
    check("t36_ready", 64'(fu_ready), 64'(ALL_RDY));
    squash = 1'b0;
    fu_valid = '0;
    repeat (4) cycle();

    // random stream with occasional squash
    for (int c = 0; c < 10000; c++) begin
      squash = ($urandom_range(0, 199) == 0);
      for (int f = 0; f < NUM_FU; f++) begin
        fu_valid[f]   = ($urandom_range(0, 99) < 60);
        fu_data[f]    = {4'(f), 28'(seq), $urandom};
        fu_prf_idx[f] = 6'($urandom);
        fu_rob_idx[f] = 4'($urandom);
      end
      seq++;
      cycle();
    end
    squash = 1'b0;
    fu_valid = '0;
    repeat (10) cycle();
    total = 0;
    for (int f = 0; f < NUM_FU; f++) total += sbq[f].size();
    check("drain_empty", 64'(total), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
